// File: rtl/asym_fifo_pkg.sv
// Shared constants and helpers for the width-converting FIFO.
// Derived widths are recomputed per instance from the same helpers.
package asym_fifo_pkg;

    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Full as soon as free space cannot hold one more whole word.
    function automatic int unsigned full_thresh(input int unsigned depthr,
                                                input int unsigned ratio);
        return depthr - ratio;
    endfunction

    localparam int unsigned WIDTHW_DEF  = 32;
    localparam int unsigned WIDTHR_DEF  = 8;
    localparam int unsigned DEPTHW_DEF  = 64;
    localparam int unsigned RATIO       = WIDTHW_DEF / WIDTHR_DEF;
    localparam int unsigned DEPTHR      = DEPTHW_DEF * RATIO;
    localparam int unsigned AW_W        = log2c(DEPTHW_DEF);
    localparam int unsigned AW_R        = log2c(DEPTHR);
    localparam int unsigned LOG2RATIO   = log2c(RATIO);
    localparam int unsigned LVLW        = AW_R + 1;
    localparam int unsigned FULL_THRESH = full_thresh(DEPTHR, RATIO);

endpackage

// File: rtl/asym_ram_w2r.sv
// Single-clock asymmetric RAM: one wide write port, one narrow registered read port.
// Storage is banked by narrow slice so each bank has exactly one writer.
module asym_ram_w2r
    import asym_fifo_pkg::*;
#(
    parameter int unsigned WIDTHW = WIDTHW_DEF,
    parameter int unsigned WIDTHR = WIDTHR_DEF,
    parameter int unsigned DEPTHW = DEPTHW_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        i_wr_en,
    input  logic [log2c(DEPTHW)-1:0]                    i_wr_addr,
    input  logic [WIDTHW-1:0]                           i_wr_data,
    input  logic                                        i_rd_en,
    input  logic [log2c(DEPTHW*(WIDTHW/WIDTHR))-1:0]    i_rd_addr,
    output logic [WIDTHR-1:0]                           o_rd_data
);

    localparam int unsigned L_RATIO = WIDTHW / WIDTHR;
    localparam int unsigned L_AW_R  = log2c(DEPTHW * L_RATIO);
    localparam int unsigned L_LOG2R = log2c(L_RATIO);

    logic [L_RATIO-1:0][WIDTHR-1:0] w_bank_rd;
    logic [WIDTHR-1:0]              r_rd_data;

    for (genvar g = 0; g < int'(L_RATIO); g++) begin : g_slice
        logic [WIDTHR-1:0] r_bank [DEPTHW];

        always_ff @(posedge clk) begin
            if (i_wr_en) r_bank[i_wr_addr] <= i_wr_data[g*WIDTHR +: WIDTHR];
        end

        assign w_bank_rd[g] = r_bank[i_rd_addr[L_AW_R-1:L_LOG2R]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= w_bank_rd[i_rd_addr[L_LOG2R-1:0]];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Width-converting FIFO: wide words in, narrow units out, low unit first.
// Occupancy is tracked in narrow units; fullness derives from level, not pointers.
module asym_fifo_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int unsigned WIDTHW = WIDTHW_DEF,
    parameter int unsigned WIDTHR = WIDTHR_DEF,
    parameter int unsigned DEPTHW = DEPTHW_DEF
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            wr_valid,
    output logic                                            wr_ready,
    input  logic [WIDTHW-1:0]                               wr_data,
    input  logic                                            rd_en,
    output logic [WIDTHR-1:0]                               rd_data,
    output logic                                            rd_valid,
    output logic [log2c(DEPTHW*(WIDTHW/WIDTHR))+1-1:0]      level,
    output logic                                            empty,
    output logic                                            full,
    output logic                                            overflow,
    output logic                                            underflow,
    input  logic                                            clr_err
);

    localparam int unsigned L_RATIO  = WIDTHW / WIDTHR;
    localparam int unsigned L_DEPTHR = DEPTHW * L_RATIO;
    localparam int unsigned L_AW_W   = log2c(DEPTHW);
    localparam int unsigned L_AW_R   = log2c(L_DEPTHR);
    localparam int unsigned L_LVLW   = L_AW_R + 1;
    localparam int unsigned L_THRESH = full_thresh(L_DEPTHR, L_RATIO);

    logic [L_AW_W-1:0] r_wptr;
    logic [L_AW_R-1:0] r_rptr;
    logic [L_LVLW-1:0] r_level;
    logic [L_LVLW-1:0] w_level_nxt;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_udf;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_acc;
    logic              w_rd_acc;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level > L_LVLW'(L_THRESH));
    assign w_wr_acc = wr_valid && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc) w_level_nxt = w_level_nxt + L_LVLW'(L_RATIO);
        if (w_rd_acc) w_level_nxt = w_level_nxt - L_LVLW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + L_AW_W'(1);
            if (w_rd_acc) r_rptr <= r_rptr + L_AW_R'(1);
            r_level    <= w_level_nxt;
            r_rd_valid <= w_rd_acc;
            // A new error in the same cycle as clr_err keeps the flag set.
            r_ovf      <= (r_ovf && !clr_err) || (wr_valid && w_full);
            r_udf      <= (r_udf && !clr_err) || (rd_en && w_empty);
        end
    end

    asym_ram_w2r #(
        .WIDTHW (WIDTHW),
        .WIDTHR (WIDTHR),
        .DEPTHW (DEPTHW)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rptr),
        .o_rd_data (rd_data)
    );

    assign wr_ready  = !w_full;
    assign rd_valid  = r_rd_valid;
    assign level     = r_level;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Directed bench for asym_fifo_ctrl at default widths (32-bit in, 8-bit out, 64 words).
module tb_asym_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [8:0]  level;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic        clr_err;

    int n_cmp = 0;
    int n_err = 0;

    asym_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_valid;
        logic [31:0] wr_data;
        logic        rd_en;
        logic        clr_err;
        logic        e_rd_valid;
        logic [7:0]  e_rd_data;
        int          e_level;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [7:0] byte_at(input int k);
        return 8'((k * 13 + 5) & 255);
    endfunction

    function automatic logic [31:0] word_at(input int j);
        return {byte_at(4*j+3), byte_at(4*j+2), byte_at(4*j+1), byte_at(4*j)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int rx_cnt;
        int max_lvl;
        bit seq_bad;

        // {wr_valid, wr_data, rd_en, clr_err, rd_valid, rd_data, level, empty, full, ovf, udf}
        vecs[0] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h44332211, 1'b0, 1'b0, 1'b0, 8'h00, 4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h11, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h33, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h44, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h44, 0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);

        // Table: underflow/clr_err, then one word read back low byte first
        for (int i = 0; i < 10; i++) begin
            wr_valid = vecs[i].wr_valid;
            wr_data  = vecs[i].wr_data;
            rd_en    = vecs[i].rd_en;
            clr_err  = vecs[i].clr_err;
            tick();
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rd_valid));
            chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd_data));
            chk($sformatf("vec%0d_level", i), 32'(level), vecs[i].e_level);
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d_udf", i), 32'(underflow), 32'(vecs[i].e_udf));
        end
        idle_inputs();

        // Fill to capacity, overflow, then drain below the full threshold
        do_reset();
        for (int j = 0; j < 64; j++) begin
            wr_valid = 1'b1;
            wr_data  = word_at(j);
            tick();
        end
        wr_valid = 1'b0;
        chk("fill_level", 32'(level), 32'd256);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        chk("fill_ovf_clear", 32'(overflow), 32'd0);
        wr_valid = 1'b1;
        wr_data  = word_at(64);
        tick();
        wr_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd256);
        rd_en = 1'b1;
        tick();
        chk("drain1_data", 32'(rd_data), 32'(byte_at(0)));
        chk("drain1_level", 32'(level), 32'd255);
        chk("drain1_full", 32'(full), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("drain%0d_data", k + 1), 32'(rd_data), 32'(byte_at(k)));
        end
        rd_en = 1'b0;
        chk("drain4_level", 32'(level), 32'd252);
        chk("drain4_full", 32'(full), 32'd0);
        chk("drain4_wr_ready", 32'(wr_ready), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Steady stream: one word per 4 cycles, rd_en held high, across pointer wrap
        do_reset();
        rx_cnt  = 0;
        max_lvl = 0;
        seq_bad = 1'b0;
        for (int k = 0; k <= 320; k++) begin
            wr_valid = (k < 320) && (k % 4 == 0);
            wr_data  = word_at(k / 4);
            rd_en    = (k >= 1);
            tick();
            if (rd_valid) begin
                if (rd_data !== byte_at(rx_cnt)) begin
                    if (!seq_bad) chk($sformatf("stream_byte%0d", rx_cnt), 32'(rd_data),
                                      32'(byte_at(rx_cnt)));
                    seq_bad = 1'b1;
                end
                rx_cnt++;
            end else if (k >= 1) begin
                seq_bad = 1'b1;
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        idle_inputs();
        chk("stream_count", 32'(rx_cnt), 32'd320);
        chk("stream_continuous", 32'(seq_bad), 32'd0);
        chk("stream_max_level", 32'(max_lvl <= 4), 32'd1);
        chk("stream_flags", {30'd0, overflow, underflow}, 32'd0);
        chk("stream_empty", 32'(empty), 32'd1);

        // Simultaneous write and read at level 3
        do_reset();
        wr_valid = 1'b1;
        wr_data  = 32'h0D0C0B0A;
        tick();
        wr_valid = 1'b0;
        rd_en    = 1'b1;
        tick();
        chk("sim_pre_data", 32'(rd_data), 32'h0A);
        chk("sim_pre_level", 32'(level), 32'd3);
        wr_valid = 1'b1;
        wr_data  = 32'h1D1C1B1A;
        tick();
        wr_valid = 1'b0;
        chk("sim_level", 32'(level), 32'd6);
        chk("sim_rd_valid", 32'(rd_valid), 32'd1);
        chk("sim_data", 32'(rd_data), 32'h0B);
        tick();
        chk("sim_next0", 32'(rd_data), 32'h0C);
        tick();
        chk("sim_next1", 32'(rd_data), 32'h0D);
        tick();
        chk("sim_next2", 32'(rd_data), 32'h1A);
        rd_en = 1'b0;
        chk("sim_level_end", 32'(level), 32'd3);

        // Reset mid-operation with a read requested at the reset edge
        do_reset();
        wr_valid = 1'b1;
        wr_data  = 32'h04030201;
        tick();
        wr_data  = 32'h08070605;
        tick();
        wr_valid = 1'b0;
        rd_en    = 1'b1;
        rst_n    = 1'b0;
        tick();
        rd_en    = 1'b0;
        rst_n    = 1'b1;
        chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_rd_data", 32'(rd_data), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 32'hDDCCBBAA;
        tick();
        wr_valid = 1'b0;
        rd_en    = 1'b1;
        tick();
        rd_en    = 1'b0;
        chk("mrst_first", 32'(rd_data), 32'hAA);
        chk("mrst_first_valid", 32'(rd_valid), 32'd1);
        chk("mrst_level_after", 32'(level), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/asym_fifo_ctrl.md
Name: asym_fifo_ctrl

Overview:
- Single-clock width-converting FIFO. Accepts wide words (default 32-bit) and delivers narrow units (default 8-bit), in order.
- Owns the write/read pointer sequencing, occupancy tracking, flow control and error flags around an asymmetric RAM: wide write-only port, narrow read-only port.
- Sits between a word-oriented producer (DMA/bus side) and a byte-oriented consumer (serializer/UART-class logic).

Parameters:
- WIDTHW, 32, write word width in bits.
- WIDTHR, 8, read unit width in bits. WIDTHW/WIDTHR must be a power of two, ≥2.
- DEPTHW, 64, depth in write words. Must be a power of two.
- Derived localparams (not overridable):
  - RATIO = WIDTHW/WIDTHR.
  - DEPTHR = DEPTHW*RATIO.
  - AW_W = log2(DEPTHW).
  - AW_R = log2(DEPTHR).
  - LOG2RATIO = log2(RATIO).
  - LVLW = AW_R+1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_valid  in  1  producer presents wr_data.
- wr_ready  out  1  space for one full word; a write occurs when wr_valid && wr_ready.
- wr_data  in  WIDTHW  write word; bits [WIDTHR-1:0] are read out first.
- rd_en  in  1  request one read unit.
- rd_data  out  WIDTHR  read unit, registered.
- rd_valid  out  1  rd_data holds a new unit this cycle.
- level  out  LVLW  occupancy in read units, 0..DEPTHR.
- empty  out  1  level==0.
- full  out  1  level > DEPTHR-RATIO, i.e. free space is less than one word.
- overflow  out  1  sticky: wr_valid seen while wr_ready=0.
- underflow  out  1  sticky: rd_en seen while empty=1.
- clr_err  in  1  clears both sticky flags.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Pointers and level go to 0.
  - rd_valid=0, rd_data=0, overflow=0, underflow=0.
  - empty=1, full=0, wr_ready=1 in the cycle after the reset edge.
  - RAM contents are not cleared.
  - Reset asserted mid-operation discards all buffered data. It does not matter whether a read is in flight; rd_valid is 0 the following cycle.
- Pointers:
  - wptr is AW_W bits and advances by 1 per accepted write.
  - rptr is AW_R bits and advances by 1 per accepted read.
  - Both wrap modulo their depth with no special handling. Fullness comes from level, not from pointer compare.
- Write:
  - wr_ready = !full (combinational from level).
  - An accepted write stores wr_data so that narrow unit i sits at narrow address {wptr, i[LOG2RATIO-1:0]}, for i = 0..RATIO-1.
- Read:
  - Accepted when rd_en && !empty.
  - rd_data is registered from narrow address rptr, with 1-cycle latency; rd_valid pulses the next cycle.
  - rd_data holds its value when no read is accepted.
  - Read-before-write is not a concern: a unit is readable only after its word's write cycle has completed, because level updates at the same edge as the write.
- Level update per edge:
  - level + RATIO·(write accepted) − 1·(read accepted).
  - Simultaneous write and read are both honoured in the same cycle.
  - Level never exceeds DEPTHR and never goes below 0.
- Error flags:
  - A write attempted while full is dropped; overflow is set.
  - A read attempted while empty is ignored, with no rd_valid; underflow is set.
  - If clr_err and a new error occur in the same cycle, the new error wins: the flag is set.
- No internal state machine beyond the counters. Throughput is one word in and one unit out per cycle.

Decomposition:
- Shared package asym_fifo_pkg holds:
  - the log2 constant function;
  - the derived-width localparams;
  - the "full when free < RATIO" rule constant (FULL_THRESH = DEPTHR-RATIO).
- One sub-module, asym_ram_w2r: single-clock asymmetric RAM, wide write port plus narrow registered read port with read enable. It uses a generate loop writing RATIO narrow slices.
- The controller (pointers, level, flags, handshake) lives in asym_fifo_ctrl.

Test Plan:
- Reset, then write 0x44332211, then 4 rd_en cycles:
  - rd_data is 0x11, 0x22, 0x33, 0x44, each with rd_valid the cycle after its rd_en;
  - level goes 4,3,2,1,0; empty=1 at the end.
- Write 64 consecutive words with no reads:
  - level=256, full=1, wr_ready=0;
  - a 65th wr_valid is dropped and overflow=1;
  - one read gives level=255 with full still 1;
  - after 4 reads, level=252 and full=0.
- Steady state: write once every 4th cycle while rd_en is held high:
  - byte stream is continuous and ordered across the pointer wrap (run more than 300 bytes);
  - level never exceeds 4; no flags set.
- Same-cycle write and read at level=3: next cycle level=6 and the correct byte is returned.
- rd_en at empty after reset: no rd_valid, underflow=1; clr_err clears it; clr_err and rd_en at empty in the same cycle leave underflow=1.
- Write 2 words, issue 1 read, assert rst_n=0 for one cycle:
  - next cycle rd_valid=0, level=0, empty=1;
  - a fresh write 0xDDCCBBAA then reads back 0xAA first.
